// File: rtl/imem_loader.sv
// imem_loader: boot loader that fills the instruction RAM from a byte stream.
// Stream layout (all fields little-endian 32-bit): count N, N data words, checksum.
// Each assembled data word is written to RAM in a single cycle at BASE_ADDR + 4*idx.
// The checksum is the mod-2^32 sum of all data words.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   start_i         one-cycle pulse, begins a load from IDLE or ERR
//   byte_valid_i    byte_i carries a valid stream byte
//   byte_i          stream byte
//   byte_ready_o    byte accepted on this edge when byte_valid_i is also high
//   we_o            RAM write enable (one cycle per word)
//   addr_o          RAM byte address
//   data_o          RAM write data
//   busy_o          load in progress
//   cpu_hold_o      keep the CPU in reset
//   done_o          one-cycle pulse, load finished with a good checksum
//   err_o           sticky error, cleared by the next accepted start_i
//   words_loaded_o  words written in the current/last load
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0001_0200,
    parameter int unsigned MAX_WORDS = 16326
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        byte_ready_o,
    output logic        we_o,
    output logic [31:0] addr_o,
    output logic [31:0] data_o,
    output logic        busy_o,
    output logic        cpu_hold_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] words_loaded_o
);

    typedef enum logic [2:0] {
        StIdle, StHdr, StData, StWr, StCsum, StDone, StErr
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;      // bytes of the current field already received
    logic [31:0] shift_q, shift_d;  // field assembly, new bytes enter at the top
    logic [31:0] n_q, n_d;
    logic [31:0] idx_q, idx_d;      // doubles as words_loaded
    logic [31:0] sum_q, sum_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;

    logic        accept;
    logic        last_byte;
    logic [31:0] shift_next;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        n_d     = n_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;

        byte_ready_o = (state_q == StHdr) || (state_q == StData) || (state_q == StCsum);
        accept       = byte_valid_i && byte_ready_o;
        // After four shifts the first byte sits in [7:0]: little-endian assembly.
        shift_next   = {byte_i, shift_q[31:8]};
        last_byte    = accept && (cnt_q == 2'd3);

        if (accept) begin
            shift_d = shift_next;
            cnt_d   = cnt_q + 2'd1;
        end

        unique case (state_q)
            StIdle, StErr: begin
                if (start_i) begin
                    state_d = StHdr;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    sum_d   = '0;
                    cnt_d   = '0;
                end
            end
            StHdr: begin
                if (last_byte) begin
                    n_d = shift_next;
                    if (shift_next == 32'd0) begin
                        state_d = StCsum;
                    end else if (shift_next > 32'(MAX_WORDS)) begin
                        state_d = StErr;
                        err_d   = 1'b1;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (last_byte) begin
                    addr_d  = BASE_ADDR + (idx_q << 2);
                    data_d  = shift_next;
                    state_d = StWr;
                end
            end
            StWr: begin
                sum_d   = sum_q + data_q;
                idx_d   = idx_q + 32'd1;
                state_d = (idx_q + 32'd1 == n_q) ? StCsum : StData;
            end
            StCsum: begin
                if (last_byte) begin
                    if (shift_next == sum_q) begin
                        state_d = StDone;
                    end else begin
                        state_d = StErr;
                        err_d   = 1'b1;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        we_o           = (state_q == StWr);
        busy_o         = (state_q == StHdr) || (state_q == StData) ||
                         (state_q == StWr) || (state_q == StCsum);
        cpu_hold_o     = busy_o || (state_q == StErr);
        done_o         = (state_q == StDone);
        err_o          = err_q;
        addr_o         = addr_q;
        data_o         = data_q;
        words_loaded_o = idx_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            shift_q <= '0;
            n_q     <= '0;
            idx_q   <= '0;
            sum_q   <= '0;
            addr_q  <= BASE_ADDR;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a reference model derives expected RAM writes
// and load outcomes from each byte stream; a monitor pops and compares them.
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h0001_0200;
    localparam int unsigned MAXW = 16326;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        byte_valid_i;
    logic [7:0]  byte_i;
    logic        byte_ready_o;
    logic        we_o;
    logic [31:0] addr_o;
    logic [31:0] data_o;
    logic        busy_o;
    logic        cpu_hold_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] words_loaded_o;

    imem_loader dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .byte_valid_i   (byte_valid_i),
        .byte_i         (byte_i),
        .byte_ready_o   (byte_ready_o),
        .we_o           (we_o),
        .addr_o         (addr_o),
        .data_o         (data_o),
        .busy_o         (busy_o),
        .cpu_hold_o     (cpu_hold_o),
        .done_o         (done_o),
        .err_o          (err_o),
        .words_loaded_o (words_loaded_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [31:0] words;
    } ev_t;

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  stream[$];
    logic [63:0] exp_wr[$];   // {addr, data}
    ev_t         exp_ev[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input int i);
        return {stream[i+3], stream[i+2], stream[i+1], stream[i]};
    endfunction

    function automatic void push32(input logic [31:0] w);
        for (int i = 0; i < 4; i++) stream.push_back(w[8*i +: 8]);
    endfunction

    // Reference: what a stream (possibly truncated) must produce.
    function automatic void model();
        int          sz;
        logic [31:0] n, sum, w;
        ev_t         e;
        sz = stream.size();
        if (sz < 4) return;
        n = word_at(0);
        if (n > MAXW) begin
            e.is_err = 1'b1;
            e.words  = 0;
            exp_ev.push_back(e);
            return;
        end
        sum = 0;
        for (int k = 0; k < int'(n); k++) begin
            if (sz < 8 + 4 * k) return;
            w = word_at(4 + 4 * k);
            exp_wr.push_back({BASE + 32'(4 * k), w});
            sum += w;
        end
        if (sz >= 8 + 4 * int'(n)) begin
            e.is_err = (word_at(4 + 4 * int'(n)) != sum);
            e.words  = n;
            exp_ev.push_back(e);
        end
    endfunction

    // Monitor: compare every write and completion against the scoreboard.
    initial begin
        logic        err_prev;
        logic [63:0] w;
        ev_t         e;
        err_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (we_o) begin
                    if (exp_wr.size() == 0) begin
                        check("unexpected_we", 32'd1, 32'd0);
                    end else begin
                        w = exp_wr.pop_front();
                        check("wr_addr", addr_o, w[63:32]);
                        check("wr_data", data_o, w[31:0]);
                        check("wr_hold", {31'd0, cpu_hold_o}, 32'd1);
                    end
                end
                if (done_o || (err_o && !err_prev)) begin
                    if (exp_ev.size() == 0) begin
                        check("unexpected_end", 32'd1, 32'd0);
                    end else begin
                        e = exp_ev.pop_front();
                        check("end_is_err", {31'd0, err_o}, {31'd0, e.is_err});
                        check("end_done", {31'd0, done_o}, {31'd0, !e.is_err});
                        check("end_words", words_loaded_o, e.words);
                        check("end_hold", {31'd0, cpu_hold_o}, {31'd0, e.is_err});
                    end
                end
            end
            err_prev = err_o;
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("start_err_clr", {31'd0, err_o}, 32'd0);
        check("start_busy", {31'd0, busy_o}, 32'd1);
    endtask

    task automatic send_stream(input int gap_pct, input bit rs);
        int          j, budget, sz;
        longint      n;
        bit          acc, ends;
        sz     = stream.size();
        n      = (sz >= 4) ? longint'(word_at(0)) : 0;
        ends   = (sz == 4 && n > MAXW) || (n <= MAXW && longint'(sz) == 8 + 4 * n);
        j      = 0;
        budget = 0;
        while (j < sz) begin
            @(negedge clk);
            if ($urandom_range(99) < gap_pct) begin
                byte_valid_i = 1'b0;
                byte_i       = 8'($urandom);
            end else begin
                byte_valid_i = 1'b1;
                byte_i       = stream[j];
            end
            start_i = rs && ($urandom_range(7) == 0);
            acc     = byte_valid_i && byte_ready_o;
            @(posedge clk);
            if (acc) begin
                budget = 0;
                if (j >= 4 && n <= MAXW && longint'(j) < 4 + 4 * n && (j - 4) % 4 == 3) begin
                    @(negedge clk);
                    check("we_latency", {31'd0, we_o}, 32'd1);
                end
                j++;
                if (j == sz && ends) begin
                    @(negedge clk);
                    start_i      = 1'b0;
                    byte_valid_i = 1'b0;
                    check("end_latency", {31'd0, done_o | err_o}, 32'd1);
                end
            end else if (++budget > 200) begin
                check("byte_stall", 32'd1, 32'd0);
                break;
            end
        end
        @(negedge clk);
        start_i      = 1'b0;
        byte_valid_i = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            if (exp_wr.size() == 0 && exp_ev.size() == 0) break;
        end
        check(name, 32'(exp_wr.size() + exp_ev.size()), 32'd0);
        exp_wr.delete();
        exp_ev.delete();
    endtask

    task automatic run_load(input string name, input int gap_pct, input bit rs);
        model();
        pulse_start();
        send_stream(gap_pct, rs);
        wait_drain(name);
    endtask

    function automatic void test1_stream(input logic [7:0] last);
        stream = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h17, 8'h2e, 8'h00, 8'h00,
                   8'h03, 8'h2e, 8'h8e, 8'he0, 8'h1a, 8'h5c, 8'h8e, last};
    endfunction

    task automatic check_idle_outputs(input string name);
        check({name, "_busy"}, {31'd0, busy_o}, 32'd0);
        check({name, "_hold"}, {31'd0, cpu_hold_o}, 32'd0);
        check({name, "_we"}, {31'd0, we_o}, 32'd0);
        check({name, "_done"}, {31'd0, done_o}, 32'd0);
        check({name, "_err"}, {31'd0, err_o}, 32'd0);
        check({name, "_ready"}, {31'd0, byte_ready_o}, 32'd0);
        check({name, "_addr"}, addr_o, BASE);
        check({name, "_data"}, data_o, 32'd0);
        check({name, "_words"}, words_loaded_o, 32'd0);
    endtask

    initial begin
        logic [31:0] sum, w;
        int          n;
        rst          = 1'b1;
        start_i      = 1'b0;
        byte_valid_i = 1'b0;
        byte_i       = 8'h00;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        // Normal load, N=2
        test1_stream(8'he0);
        run_load("t1", 0, 1'b0);

        // Bad checksum, then retry from ERR
        test1_stream(8'he1);
        run_load("t2", 0, 1'b0);
        check("t2_err_sticky", {31'd0, err_o}, 32'd1);
        check("t2_hold", {31'd0, cpu_hold_o}, 32'd1);
        check("t2_ready", {31'd0, byte_ready_o}, 32'd0);
        test1_stream(8'he0);
        run_load("t2_retry", 0, 1'b0);
        check("t2_retry_err", {31'd0, err_o}, 32'd0);

        // Oversize header
        stream.delete();
        push32(MAXW + 1);
        run_load("t3", 0, 1'b0);
        check("t3_err", {31'd0, err_o}, 32'd1);

        // N=0 (started from ERR)
        stream.delete();
        push32(0);
        push32(0);
        run_load("t4", 0, 1'b0);
        check("t4_words", words_loaded_o, 32'd0);

        // Backpressure and gaps, stray start pulses during the load
        test1_stream(8'he0);
        run_load("t5", 50, 1'b1);

        // Largest legal count is accepted; abandon it with reset
        stream.delete();
        push32(MAXW);
        model();
        pulse_start();
        send_stream(20, 1'b0);
        repeat (2) @(negedge clk);
        check("max_err", {31'd0, err_o}, 32'd0);
        check("max_ready", {31'd0, byte_ready_o}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("max_rst");

        // Reset mid-load after the 2nd word's 2nd byte
        test1_stream(8'he0);
        repeat (6) void'(stream.pop_back());
        model();
        pulse_start();
        send_stream(0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("t6_rst");
        wait_drain("t6");
        test1_stream(8'he0);
        run_load("t6_reload", 0, 1'b0);

        // Random loads
        for (int t = 0; t < 8; t++) begin
            stream.delete();
            n   = $urandom_range(1, 5);
            sum = 0;
            push32(n);
            for (int k = 0; k < n; k++) begin
                w = $urandom;
                push32(w);
                sum += w;
            end
            push32(($urandom_range(3) == 0) ? sum ^ (32'd1 << $urandom_range(31)) : sum);
            run_load("rand", 30, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
